// File: rtl/uart_tx_engine_if.sv
// UART TX FIFO read port between the TX FIFO and the transmit engine.
// master = engine (pops), slave = FIFO (supplies registered data).
interface uart_tx_engine_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_read
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_read
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops the TX FIFO, frames start/data/stop.
// Optional parity bit is built when UART_TX_PARITY_EN is defined.
module uart_tx_engine #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             stop2,
`ifdef UART_TX_PARITY_EN
  input  logic             parity_en,
  input  logic             parity_odd,
`endif
  uart_tx_engine_if.master fifo,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] PARITY = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic [2:0]           state;
  logic [DIV_W-1:0]     cnt;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     div_in;
  logic [DATA_BITS-1:0] shift_reg;
  logic [2:0]           bit_idx;
  logic                 stop2_q;
  logic                 stop_idx;
  logic                 bit_end;
  logic                 go_par;
  logic                 par_bit;

`ifdef UART_TX_PARITY_EN
  logic                 par_en_q;
  logic                 par_q;

  assign go_par  = par_en_q;
  assign par_bit = par_q;
`else
  assign go_par  = 1'b0;
  assign par_bit = 1'b1;
`endif

  assign div_in  = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign bit_end = (cnt == '0);

  assign fifo.fifo_read = rst_n && (state == IDLE) &&
                          tx_en && !fifo.fifo_empty;

  assign tx_busy = (state != IDLE) || fifo.fifo_read;

  assign tx_done = (state == STOP) && bit_end &&
                   (!stop2_q || stop_idx);

`ifdef UART_TX_PARITY_EN
  // Frame parity config and bit, captured with the byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else if (state == FETCH) begin
      par_en_q <= parity_en;
      par_q    <= (^fifo.fifo_data[DATA_BITS-1:0]) ^ parity_odd;
    end
  end
`endif

  // Frame sequencer: state, bit timer, shifter and registered tx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      div_q     <= '0;
      shift_reg <= '0;
      bit_idx   <= '0;
      stop2_q   <= 1'b0;
      stop_idx  <= 1'b0;
      tx        <= 1'b1;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          tx <= 1'b1;
          if (fifo.fifo_read) state <= FETCH;
        end
        (state == FETCH): begin
          shift_reg <= fifo.fifo_data[DATA_BITS-1:0];
          div_q     <= div_in;
          stop2_q   <= stop2;
          cnt       <= div_in - 1'b1;
          tx        <= 1'b0;
          state     <= START;
        end
        (state == START): begin
          if (bit_end) begin
            cnt     <= div_q - 1'b1;
            bit_idx <= '0;
            tx      <= shift_reg[0];
            state   <= DATA;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        (state == DATA): begin
          if (bit_end) begin
            cnt <= div_q - 1'b1;
            if (bit_idx == LAST_BIT) begin
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              if (go_par) begin
                tx    <= par_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        (state == PARITY): begin
          if (bit_end) begin
            cnt      <= div_q - 1'b1;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        (state == STOP): begin
          tx <= 1'b1;
          if (bit_end) begin
            if (stop2_q && !stop_idx) begin
              stop_idx <= 1'b1;
              cnt      <= div_q - 1'b1;
            end else begin
              stop_idx <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: FIFO model, line monitor.
// Parity frames are exercised when UART_TX_PARITY_EN is defined.
module tb_uart_tx_engine;

  localparam int DB = 8;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         nstop;
    bit         par_en;
    bit         par_odd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        tx_en;
  logic [15:0] baud_div;
  logic        stop2;
  logic        tx;
  logic        tx_busy;
  logic        tx_done;
`ifdef UART_TX_PARITY_EN
  logic        parity_en;
  logic        parity_odd;
`endif

  uart_tx_engine_if bus ();

  uart_tx_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .baud_div   (baud_div),
    .stop2      (stop2),
`ifdef UART_TX_PARITY_EN
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
`endif
    .fifo       (bus.master),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];
  logic [7:0] fq[$];
  int   rd_cnt  = 0;
  int   last_gap = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  function automatic bit exp_bit(input exp_t e, input int b);
    logic [7:0] d;
    d = e.data;
    if (b == 0) return 1'b0;
    if (b <= DB) return d[b-1];
    if (e.par_en && b == DB + 1) return (^d) ^ e.par_odd;
    return 1'b1;
  endfunction

  // FIFO model: registered read data one cycle after the pop
  initial bus.fifo_empty = 1'b1;
  initial bus.fifo_data  = 8'h00;
  always @(posedge clk) begin
    if (bus.fifo_read) begin
      rd_cnt++;
      if (fq.size() > 0) bus.fifo_data <= fq.pop_front();
      else check("pop_on_empty", 1, 0);
    end
    bus.fifo_empty <= (fq.size() == 0);
  end

  // Line monitor: decodes each frame and checks it against the scoreboard
  initial begin
    bit   in_frame;
    exp_t e;
    int   idx, len, bad, cyc, rd_cyc, done_cyc;
    in_frame = 0; idx = 0; len = 0; bad = 0;
    cyc = 0; rd_cyc = -100; done_cyc = -100;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_frame = 0;
      end else begin
        if (bus.fifo_read) rd_cyc = cyc;
        if (!in_frame && tx_done) check("stray_done", 1, 0);
        if (!in_frame && tx == 1'b0) begin
          if (sb.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            e = sb.pop_front();
            in_frame = 1;
            idx = 0; bad = 0;
            len = e.div * (1 + DB + (e.par_en ? 1 : 0) + e.nstop);
            check("start_latency", cyc - rd_cyc, 2);
            last_gap = cyc - done_cyc - 1;
          end
        end
        if (in_frame) begin
          if (idx < len && tx != exp_bit(e, idx / e.div)) bad++;
          if (tx_done) begin
            check($sformatf("frame_bits_%02h", e.data), bad, 0);
            check($sformatf("frame_len_%02h", e.data), idx + 1, len);
            done_cyc = cyc;
            in_frame = 0;
          end else if (idx > len + 4) begin
            check("frame_overrun", idx, len);
            in_frame = 0;
          end
          idx++;
        end
      end
    end
  end

  task automatic load(input logic [7:0] d, input bit expect_frame,
                      input int div, input int nstop,
                      input bit pe, input bit po);
    exp_t e;
    e.data = d; e.div = div; e.nstop = nstop;
    e.par_en = pe; e.par_odd = po;
    if (expect_frame) sb.push_back(e);
    fq.push_back(d);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_done && n < 2000);
    check(name, int'(tx_done), 1);
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 2000);
    check(name, int'(tx == 1'b0), 1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int r0;
    rst_n = 1'b0; tx_en = 1'b0; baud_div = 16'd4; stop2 = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_en = 1'b0; parity_odd = 1'b0;
`endif
    step(3);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_done", int'(tx_done), 0);
    check("rst_read", int'(bus.fifo_read), 0);
    rst_n = 1'b1;
    step(2);

    tx_en = 1'b1; baud_div = 16'd4;
    load(8'hA5, 1, 4, 1, 0, 0);
    wait_done("done_a5");
    step(4);

    r0 = rd_cnt;
    baud_div = 16'd2;
    load(8'h00, 1, 2, 1, 0, 0);
    load(8'hFF, 1, 2, 1, 0, 0);
    wait_done("done_00");
    wait_done("done_ff");
    step(4);
    check("b2b_reads", rd_cnt - r0, 2);
    check("b2b_gap", last_gap, 2);

    stop2 = 1'b1; baud_div = 16'd0;
    load(8'h3C, 1, 1, 2, 0, 0);
    wait_done("done_3c");
    step(4);

    r0 = rd_cnt;
    stop2 = 1'b0; baud_div = 16'd4;
    load(8'h5A, 1, 4, 1, 0, 0);
    wait_start("start_5a");
    step(10);
    baud_div = 16'd8; tx_en = 1'b0;
    load(8'h11, 0, 8, 1, 0, 0);
    wait_done("done_5a");
    step(30);
    check("midcfg_reads", rd_cnt - r0, 1);
    check("midcfg_fifo_left", fq.size(), 1);
    fq.delete();
    step(3);

`ifdef UART_TX_PARITY_EN
    tx_en = 1'b1; baud_div = 16'd2;
    parity_en = 1'b1; parity_odd = 1'b0;
    load(8'h07, 1, 2, 1, 1, 0);
    wait_done("done_par_even");
    step(2);
    parity_odd = 1'b1;
    load(8'h07, 1, 2, 1, 1, 1);
    wait_done("done_par_odd");
    step(2);
    parity_en = 1'b0; tx_en = 1'b0;
    step(2);
`endif

    tx_en = 1'b1; baud_div = 16'd4;
    load(8'hC3, 1, 4, 1, 0, 0);
    wait_start("start_c3");
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", int'(tx), 1);
    check("midrst_busy", int'(tx_busy), 0);
    check("midrst_done", int'(tx_done), 0);
    step(1);
    rst_n = 1'b1;
    r0 = rd_cnt;
    step(20);
    check("postrst_reads", rd_cnt - r0, 0);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
